// File: rtl/pc_sequencer.sv
// pc_sequencer: PC / IF-ID / ID-EX pipeline control sequencer.
// Handles halt, memory wait (with timeout), branch/jump redirects and load-use stalls.
// Ports:
//   clk, rst (sync, active-high)
//   halt, mem_busy, branch_taken/branch_target, jump_id/jump_target, load_use
//   pc_enable, pc_jump, pc_jump_address, ifid_enable, ifid_flush, idex_flush
//   halted, timeout_err (sticky), stall_count (saturating load-use stall count)
module pc_sequencer #(
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         halt,
    input  logic         mem_busy,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump_id,
    input  logic [N-1:0] jump_target,
    input  logic         load_use,
    output logic         pc_enable,
    output logic         pc_jump,
    output logic [N-1:0] pc_jump_address,
    output logic         ifid_enable,
    output logic         ifid_flush,
    output logic         idex_flush,
    output logic         halted,
    output logic         timeout_err,
    output logic [15:0]  stall_count
);

    typedef enum logic [1:0] {
        RUN,
        REDIRECT,
        MEMWAIT,
        HALTED
    } state_t;

    localparam logic [6:0] WAIT_LIMIT = 7'(TIMEOUT);

    state_t        state, state_n;
    logic [N-1:0]  tgt, tgt_n;
    logic          kind_br, kind_br_n;
    logic          pend, pend_n;
    logic [6:0]    wait_cnt, wait_cnt_n;
    logic          timeout_n;
    logic [15:0]   stall_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            tgt         <= '0;
            kind_br     <= 1'b0;
            pend        <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            stall_count <= '0;
        end else begin
            state       <= state_n;
            tgt         <= tgt_n;
            kind_br     <= kind_br_n;
            pend        <= pend_n;
            wait_cnt    <= wait_cnt_n;
            timeout_err <= timeout_n;
            stall_count <= stall_n;
        end
    end

    always_comb begin
        state_n     = state;
        tgt_n       = tgt;
        kind_br_n   = kind_br;
        pend_n      = pend;
        wait_cnt_n  = wait_cnt;
        timeout_n   = timeout_err;
        stall_n     = stall_count;
        pc_enable   = 1'b0;
        pc_jump     = 1'b0;
        ifid_enable = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;

        unique case (state)
            RUN: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (mem_busy) begin
                    state_n    = MEMWAIT;
                    wait_cnt_n = '0;
                    // A redirect arriving with the stall is kept for later.
                    if (branch_taken) begin
                        tgt_n     = branch_target;
                        kind_br_n = 1'b1;
                        pend_n    = 1'b1;
                    end else if (jump_id) begin
                        tgt_n     = jump_target;
                        kind_br_n = 1'b0;
                        pend_n    = 1'b1;
                    end
                end else if (branch_taken) begin
                    tgt_n     = branch_target;
                    kind_br_n = 1'b1;
                    state_n   = REDIRECT;
                end else if (jump_id) begin
                    tgt_n     = jump_target;
                    kind_br_n = 1'b0;
                    state_n   = REDIRECT;
                end else if (load_use) begin
                    idex_flush = 1'b1;
                    if (stall_count != 16'hFFFF) begin
                        stall_n = stall_count + 16'd1;
                    end
                end else begin
                    pc_enable   = 1'b1;
                    ifid_enable = 1'b1;
                end
            end

            REDIRECT: begin
                pc_enable  = 1'b1;
                pc_jump    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = kind_br;
                state_n    = halt ? HALTED : RUN;
            end

            MEMWAIT: begin
                // First event wins, except a branch replaces a pending jump.
                if (branch_taken && !(pend && kind_br)) begin
                    tgt_n     = branch_target;
                    kind_br_n = 1'b1;
                    pend_n    = 1'b1;
                end else if (jump_id && !pend) begin
                    tgt_n     = jump_target;
                    kind_br_n = 1'b0;
                    pend_n    = 1'b1;
                end
                if (!mem_busy) begin
                    state_n    = pend_n ? REDIRECT : RUN;
                    pend_n     = 1'b0;
                    wait_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + 7'd1;
                    if (wait_cnt_n >= WAIT_LIMIT) begin
                        timeout_n = 1'b1;
                        state_n   = HALTED;
                    end
                end
            end

            HALTED: begin
            end

            default: begin
                state_n = RUN;
            end
        endcase
    end

    assign pc_jump_address = tgt;
    assign halted          = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Per-cycle expected outputs go to a scoreboard queue and are compared at negedge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt, mem_busy, branch_taken, jump_id, load_use;
    logic [31:0] branch_target, jump_target;
    logic        pc_enable, pc_jump, ifid_enable, ifid_flush, idex_flush;
    logic        halted, timeout_err;
    logic [31:0] pc_jump_address;
    logic [15:0] stall_count;

    int nvec = 0;
    int nerr = 0;

    // ctl = {pc_enable, pc_jump, ifid_enable, ifid_flush, idex_flush, halted, timeout_err}
    localparam logic [6:0] C_RUN  = 7'b1010000;
    localparam logic [6:0] C_STL  = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b0000100;
    localparam logic [6:0] C_RDB  = 7'b1101100;
    localparam logic [6:0] C_RDJ  = 7'b1101000;
    localparam logic [6:0] C_HLT  = 7'b0000010;
    localparam logic [6:0] C_HTO  = 7'b0000011;

    typedef struct {
        logic        r, h, b, br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        lu;
        logic [6:0]  ctl;
        logic [31:0] tgt;
        logic [15:0] stall;
    } vec_t;

    logic [54:0] sb[$];

    pc_sequencer #(.N(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .halt(halt), .mem_busy(mem_busy),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_id(jump_id), .jump_target(jump_target), .load_use(load_use),
        .pc_enable(pc_enable), .pc_jump(pc_jump),
        .pc_jump_address(pc_jump_address), .ifid_enable(ifid_enable),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .timeout_err(timeout_err),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic r, h, b, br, input logic [31:0] bt,
        input logic j, input logic [31:0] jt, input logic lu,
        input logic [6:0] ctl, input logic [31:0] tgt, input logic [15:0] stall);
        vec_t s;
        s.r = r; s.h = h; s.b = b; s.br = br; s.bt = bt;
        s.j = j; s.jt = jt; s.lu = lu;
        s.ctl = ctl; s.tgt = tgt; s.stall = stall;
        return s;
    endfunction

    function automatic logic [54:0] sample();
        return {pc_enable, pc_jump, ifid_enable, ifid_flush, idex_flush,
                halted, timeout_err, pc_jump_address, stall_count};
    endfunction

    task automatic drive(input vec_t s);
        @(posedge clk);
        #1;
        rst           = s.r;
        halt          = s.h;
        mem_busy      = s.b;
        branch_taken  = s.br;
        branch_target = s.bt;
        jump_id       = s.j;
        jump_target   = s.jt;
        load_use      = s.lu;
        sb.push_back({s.ctl, s.tgt, s.stall});
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t t[$];
        logic [54:0] e, o;
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,0,0));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,0,0));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL reset[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_branch();
        vec_t t[$];
        logic [54:0] e, o;
        t.push_back(v(0,0,0,1,32'h40,0,0,0,C_STL,0,0));
        t.push_back(v(0,0,0,0,0,1,32'h77,1,C_RDB,32'h40,0));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,32'h40,0));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL branch[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t t[$];
        logic [54:0] e, o;
        for (int k = 0; k < 3; k++)
            t.push_back(v(0,0,0,0,0,0,0,1,C_LU,32'h40,16'(k)));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,32'h40,3));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL load_use[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_branch_and_jump();
        vec_t t[$];
        logic [54:0] e, o;
        t.push_back(v(0,0,0,1,32'h80,1,32'h99,0,C_STL,32'h40,3));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RDB,32'h80,3));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,32'h80,3));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL br_and_jmp[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_memwait_jump();
        vec_t t[$];
        logic [54:0] e, o;
        t.push_back(v(0,0,1,0,0,0,0,0,C_STL,32'h80,3));
        t.push_back(v(0,0,1,0,0,0,0,0,C_STL,32'h80,3));
        t.push_back(v(0,0,1,0,0,1,32'h123,0,C_STL,32'h80,3));
        t.push_back(v(0,0,1,0,0,0,0,0,C_STL,32'h123,3));
        t.push_back(v(0,0,1,0,0,0,0,0,C_STL,32'h123,3));
        t.push_back(v(0,0,0,0,0,0,0,0,C_STL,32'h123,3));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RDJ,32'h123,3));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,32'h123,3));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL memwait_jmp[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_rst_redirect();
        vec_t t[$];
        logic [54:0] e, o;
        t.push_back(v(0,0,0,1,32'h200,0,0,0,C_STL,32'h123,3));
        t.push_back(v(1,0,0,0,0,0,0,0,C_RDB,32'h200,3));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,0,0));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL rst_redirect[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_halt();
        vec_t t[$];
        logic [54:0] e, o;
        t.push_back(v(0,1,0,0,0,0,0,0,C_STL,0,0));
        t.push_back(v(0,0,0,0,0,0,0,0,C_HLT,0,0));
        t.push_back(v(0,0,1,1,32'h55,0,0,1,C_HLT,0,0));
        t.push_back(v(1,0,0,0,0,0,0,0,C_HLT,0,0));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,0,0));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL halt[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t t[$];
        logic [54:0] e, o;
        // One RUN cycle plus 64 busy MEMWAIT cycles, then HALTED.
        for (int k = 0; k < 66; k++)
            t.push_back(v(0,0,1,0,0,0,0,0,(k < 65) ? C_STL : C_HTO,0,0));
        t.push_back(v(0,0,0,0,0,0,0,0,C_HTO,0,0));
        t.push_back(v(0,0,0,0,0,0,0,1,C_HTO,0,0));
        t.push_back(v(1,0,0,0,0,0,0,0,C_HTO,0,0));
        t.push_back(v(0,0,0,0,0,0,0,0,C_RUN,0,0));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL timeout[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_stall_saturation();
        logic [54:0] e, o;
        logic [15:0] exp_cnt;
        for (int k = 0; k <= 65536; k++) begin
            exp_cnt = (k < 65535) ? 16'(k) : 16'hFFFF;
            if (k < 65536)
                drive(v(0,0,0,0,0,0,0,1,C_LU,0,exp_cnt));
            else
                drive(v(0,0,0,0,0,0,0,0,C_RUN,0,exp_cnt));
            e = sb.pop_front(); o = sample(); nvec++;
            if (o !== e) begin
                nerr++;
                if (nerr < 20)
                    $display("FAIL stall_sat[%0d] got %h want %h", k, o, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; mem_busy = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        jump_id = 1'b0; jump_target = '0; load_use = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_branch();
        test_load_use();
        test_branch_and_jump();
        test_memwait_jump();
        test_rst_redirect();
        test_halt();
        test_timeout();
        test_stall_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter N, default 32, width of addresses.
REQ-002 Parameter TIMEOUT, default 64, maximum consecutive MEMWAIT cycles before a fault.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 halt  input  1  stop-fetch request.
REQ-006 mem_busy  input  1  instruction/data memory not ready.
REQ-007 branch_taken  input  1  taken branch resolved in EX.
REQ-008 branch_target  input  N  target of branch_taken.
REQ-009 jump_id  input  1  unconditional jump decoded in ID.
REQ-010 jump_target  input  N  target of jump_id.
REQ-011 load_use  input  1  load-use hazard detected in ID.
REQ-012 pc_enable  output  1  PC register update enable.
REQ-013 pc_jump  output  1  PC selects pc_jump_address.
REQ-014 pc_jump_address  output  N  redirect target.
REQ-015 ifid_enable  output  1  IF/ID register update enable.
REQ-016 ifid_flush  output  1  clear IF/ID to a bubble.
REQ-017 idex_flush  output  1  clear ID/EX to a bubble.
REQ-018 halted  output  1  high while in HALTED.
REQ-019 timeout_err  output  1  sticky memory-timeout fault.
REQ-020 stall_count  output  16  count of load-use stall cycles, saturating at 16'hFFFF.

Function
REQ-021 States: RUN, REDIRECT, MEMWAIT, HALTED; encoded state and outputs registered or combinational only as stated below.
REQ-022 Event priority, evaluated in RUN: halt > mem_busy > branch_taken > jump_id > load_use.
REQ-023 RUN, no event: pc_enable=1, ifid_enable=1, pc_jump=0, both flushes 0.
REQ-024 RUN + halt: next state HALTED; the current cycle has pc_enable=0 and ifid_enable=0.
REQ-025 RUN + mem_busy: next state MEMWAIT; the current cycle has pc_enable=0 and ifid_enable=0.
REQ-026 RUN + branch_taken: latch branch_target and a kind=BR flag; next state REDIRECT.
  Current cycle: pc_enable=0, ifid_enable=0.
REQ-027 RUN + jump_id, with no branch_taken: latch jump_target and kind=JMP; next state REDIRECT.
  Current cycle: pc_enable=0, ifid_enable=0.
REQ-028 RUN + load_use only (combinational, same cycle): pc_enable=0, ifid_enable=0, idex_flush=1.
  State stays RUN; stall_count increments by 1.
REQ-029 REDIRECT lasts exactly one cycle with pc_enable=1, pc_jump=1, pc_jump_address=latched target, ifid_flush=1, ifid_enable=0.
  idex_flush=1 only when kind=BR; next state RUN.
REQ-030 Redirect latency: the PC loads the target on the second rising edge after the cycle in which branch_taken or jump_id was sampled.
REQ-031 In REDIRECT, jump_id, branch_taken and load_use are ignored as wrong-path.
  halt in REDIRECT: the redirect completes, then next state HALTED.
REQ-032 MEMWAIT: pc_enable=0, ifid_enable=0; a 7-bit wait counter increments each cycle.
REQ-033 MEMWAIT, mem_busy low: return to RUN, clear the wait counter.
  If a branch_taken or jump_id was captured while in MEMWAIT, go to REDIRECT instead.
  Capture rule: first event captured; branch_taken overrides a captured jump_id.
REQ-034 If the wait counter reaches TIMEOUT with mem_busy still high: set timeout_err, next state HALTED.
REQ-035 HALTED: pc_enable=0, ifid_enable=0, halted=1; the state is exited only by rst.
REQ-036 pc_jump_address holds the last latched target when pc_jump=0.
REQ-037 stall_count saturates at 16'hFFFF and never wraps.

Reset
REQ-038 On rst sampled high at a clock edge:
  state=RUN; stall_count=0; timeout_err=0; wait counter=0; latched target=0; pending capture cleared.
REQ-039 rst has priority over every event, including an active REDIRECT or MEMWAIT.
  The cycle after reset deasserts shows the RUN outputs of REQ-023.

Verification
REQ-040 Bench shall cover: pulse branch_taken=1, branch_target=32'h40 in RUN.
  -> next cycle: pc_jump=1, pc_jump_address=32'h40, ifid_flush=1, idex_flush=1; the cycle after: RUN.
REQ-041 Bench shall cover: load_use high for 3 cycles.
  -> pc_enable=0 and idex_flush=1 on all 3 cycles; stall_count=3.
REQ-042 Bench shall cover: branch_taken and jump_id high together.
  -> the REDIRECT target equals branch_target and idex_flush=1.
REQ-043 Bench shall cover: mem_busy for 5 cycles with a jump_id pulse inside.
  -> 5 MEMWAIT cycles, then REDIRECT to jump_target with idex_flush=0.
REQ-044 Bench shall cover: mem_busy held for TIMEOUT+2 cycles.
  -> timeout_err=1 and halted=1 stay high until rst; after rst, both are 0.
REQ-045 Bench shall cover: rst asserted during REDIRECT.
  -> the next cycle has pc_jump=0, stall_count=0, state RUN.
